// File: rtl/selfcomp_pkg.sv
// Shared definitions for the self-composition leak monitor.
//   state_e        : monitor FSM states (2-bit encoding)
//   DEFAULT_DATA_W : default result width of one SE copy
package selfcomp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_PARTIAL = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int DEFAULT_DATA_W = 128;

endpackage

// File: rtl/selfcomp_capture_lane.sv
// One capture lane per observed SE copy. It remembers whether this copy has
// already produced its first valid output in the current transaction and
// keeps that first result. Later or held valids are ignored.
//
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : start of a new transaction, drops seen bit and result
//   sample_en    : monitor is waiting for outputs (ARMED or PARTIAL)
//   in_valid     : this copy's output valid
//   in_result    : this copy's output result
//   ref_result   : copy 0's first result, as known in this cycle
//   seen         : registered seen bit
//   seen_next    : seen bit including a capture happening this cycle
//   result       : registered first result
//   mismatch     : this copy's first result (including one being captured
//                  now) differs from ref_result; only meaningful once
//                  the copy is seen
module selfcomp_capture_lane
  import selfcomp_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              sample_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] ref_result,
  output logic              seen,
  output logic              seen_next,
  output logic [DATA_W-1:0] result,
  output logic              mismatch
);

  logic              seen_q, seen_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              capture;
  logic [DATA_W-1:0] cur_result;

  always_comb begin
    capture    = sample_en & in_valid & ~seen_q;
    seen_next  = seen_q | capture;
    cur_result = capture ? in_result : result_q;
    seen_d     = clear ? 1'b0 : seen_next;
    result_d   = clear ? '0 : cur_result;
    // Comparing the effective value lets a lane captured earlier be checked
    // in the same cycle copy 0 finally arrives.
    mismatch   = seen_next & (cur_result != ref_result);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seen_q   <= 1'b0;
      result_q <= '0;
    end else begin
      seen_q   <= seen_d;
      result_q <= result_d;
    end
  end

  assign seen   = seen_q;
  assign result = result_q;

endmodule

// File: rtl/selfcomp_leak_monitor.sv
// Self-composition monitor for NUM_COPIES lockstep SE copies fed identical
// stimulus. From input acceptance it waits for every copy's first valid
// output and flags timing divergence (skew beyond MAX_SKEW, or a timeout
// with only some copies finished) and result divergence (a first result
// differing from copy 0's). Purely observing; drives nothing into the SEs.
//
// Handshake: a transaction is accepted on a rising edge where io_in_valid
// and io_in_ready are both high; the monitor only watches this pair. Only
// the first valid of each copy per transaction is sampled.
//
// Ports:
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   io_in_valid/ready : shared SE input handshake
//   io_out_valid    : per-copy output valid (bit i = copy i)
//   io_out_result   : per-copy result, copy i at [i*DATA_W +: DATA_W]
//   anyValid/allValid : OR/AND of io_out_valid (combinational)
//   timingLeak, resultLeak, timeout : sticky per-transaction flags
//   timingLeakDone  : high while in DONE
//   io_out_cntr     : latency of the first-finishing copy
//   skew            : cycles spent between first and last copy valid
//   dbg_state       : current FSM state
module selfcomp_leak_monitor
  import selfcomp_pkg::*;
#(
  parameter int NUM_COPIES = 2,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int CNTR_W     = 8,
  parameter int MAX_SKEW   = 0,
  parameter int MAX_WAIT   = 200
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_in_valid,
  input  logic                         io_in_ready,
  input  logic [NUM_COPIES-1:0]        io_out_valid,
  input  logic [NUM_COPIES*DATA_W-1:0] io_out_result,
  output logic                         anyValid,
  output logic                         allValid,
  output logic                         timingLeak,
  output logic                         resultLeak,
  output logic                         timeout,
  output logic                         timingLeakDone,
  output logic [CNTR_W-1:0]            io_out_cntr,
  output logic [CNTR_W-1:0]            skew,
  output logic [1:0]                   dbg_state
);

  state_e              state_q, state_d;
  logic [CNTR_W-1:0]   lat_q, lat_d;
  logic [CNTR_W-1:0]   skew_q, skew_d;
  logic [CNTR_W-1:0]   cntr_q, cntr_d;
  logic                tleak_q, tleak_d;
  logic                rleak_q, rleak_d;
  logic                tout_q, tout_d;

  logic                accept;
  logic                sample_en;
  logic                clear;
  logic                cap0;
  logic [DATA_W-1:0]   ref_result;
  logic [NUM_COPIES-1:0] seen_vec, seen_next_vec, mismatch_vec;
  logic [DATA_W-1:0]   lane_result [NUM_COPIES];
  logic [CNTR_W-1:0]   skew_inc;

  assign accept    = io_in_valid & io_in_ready;
  assign sample_en = (state_q == ST_ARMED) || (state_q == ST_PARTIAL);
  assign clear     = accept & ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Reference is copy 0's first result: straight from the input in the
  // cycle copy 0 is captured, from its lane register afterwards.
  assign cap0       = sample_en & io_out_valid[0] & ~seen_vec[0];
  assign ref_result = cap0 ? io_out_result[DATA_W-1:0] : lane_result[0];

  for (genvar i = 0; i < NUM_COPIES; i++) begin : g_lane
    selfcomp_capture_lane #(.DATA_W(DATA_W)) u_lane (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .sample_en  (sample_en),
      .in_valid   (io_out_valid[i]),
      .in_result  (io_out_result[i*DATA_W +: DATA_W]),
      .ref_result (ref_result),
      .seen       (seen_vec[i]),
      .seen_next  (seen_next_vec[i]),
      .result     (lane_result[i]),
      .mismatch   (mismatch_vec[i])
    );
  end

  assign skew_inc = (skew_q == {CNTR_W{1'b1}}) ? skew_q : skew_q + 1'b1;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    skew_d  = skew_q;
    cntr_d  = cntr_q;
    tleak_d = tleak_q;
    rleak_d = rleak_q;
    tout_d  = tout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_ARMED;
          lat_d   = '0;
          skew_d  = '0;
          cntr_d  = '0;
          tleak_d = 1'b0;
          rleak_d = 1'b0;
          tout_d  = 1'b0;
        end
      end
      ST_ARMED, ST_PARTIAL: begin
        lat_d = lat_q + 1'b1;
        if ((seen_vec == '0) && (|seen_next_vec)) cntr_d = lat_q;
        // Lanes compared before copy 0 arrives are against a cleared
        // register, so only trust mismatches once copy 0 is seen.
        if (seen_next_vec[0] && (|mismatch_vec)) rleak_d = 1'b1;
        if (state_q == ST_PARTIAL) begin
          skew_d = skew_inc;
          if (skew_inc > CNTR_W'(MAX_SKEW)) tleak_d = 1'b1;
        end
        // Completion wins over a timeout landing in the same cycle.
        if (&seen_next_vec) begin
          state_d = ST_DONE;
        end else if (lat_q == CNTR_W'(MAX_WAIT)) begin
          state_d = ST_DONE;
          tout_d  = 1'b1;
          if (|seen_next_vec) tleak_d = 1'b1;
        end else if (|seen_next_vec) begin
          state_d = ST_PARTIAL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      skew_q  <= '0;
      cntr_q  <= '0;
      tleak_q <= 1'b0;
      rleak_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      skew_q  <= skew_d;
      cntr_q  <= cntr_d;
      tleak_q <= tleak_d;
      rleak_q <= rleak_d;
      tout_q  <= tout_d;
    end
  end

  assign anyValid       = |io_out_valid;
  assign allValid       = &io_out_valid;
  assign timingLeak     = tleak_q;
  assign resultLeak     = rleak_q;
  assign timeout        = tout_q;
  assign timingLeakDone = (state_q == ST_DONE);
  assign io_out_cntr    = cntr_q;
  assign skew           = skew_q;
  assign dbg_state      = state_q;

endmodule
